// File: rtl/knn_label_vote.sv
// knn_label_vote: majority vote over the kNN core's sorted neighbour list.
// After a start request it walks the K neighbour slots through knn_id, reads
// each slot's class label on knn_info, tallies one counter per label, and then
// scans the counters for the most frequent label. Ties go to the lowest label.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      vote request, sampled only while idle
//   knn_id     slot select to the kNN core
//   knn_info   label of the selected slot (combinational from knn_id)
//   busy       high whenever a vote is in progress
//   done       one-cycle pulse when a result is written
//   label_out  winning class label
//   vote_count number of votes for label_out
//   err        at least one slot of the last vote held an out-of-range label
module knn_label_vote #(
    parameter int unsigned NBR_KNN    = 4,
    parameter int unsigned NBR_LABELS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] knn_id,
    input  logic [7:0] knn_info,
    output logic       busy,
    output logic       done,
    output logic [7:0] label_out,
    output logic [7:0] vote_count,
    output logic       err
);

    localparam int unsigned CW = $clog2(NBR_KNN + 1);
    localparam int unsigned LW = (NBR_LABELS > 1) ? $clog2(NBR_LABELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SCAN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      slot_q, slot_d;
    logic [LW-1:0]   lbl_q, lbl_d;
    logic [CW-1:0]   cnt_q [NBR_LABELS];
    logic [CW-1:0]   cnt_d [NBR_LABELS];
    logic [LW-1:0]   best_label_q, best_label_d;
    logic [CW-1:0]   best_cnt_q, best_cnt_d;
    logic [7:0]      label_out_q, label_out_d;
    logic [7:0]      vote_count_q, vote_count_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            valid_c;
    logic            take_c;

    // Full 8-bit range check before the narrowed label is used as an index.
    assign valid_c = (knn_info < 8'(NBR_LABELS));
    // Strict compare keeps the lowest label on ties.
    assign take_c  = (cnt_q[lbl_q] > best_cnt_q);

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        lbl_d        = lbl_q;
        cnt_d        = cnt_q;
        best_label_d = best_label_q;
        best_cnt_d   = best_cnt_q;
        label_out_d  = label_out_q;
        vote_count_d = vote_count_q;
        err_d        = err_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < int'(NBR_LABELS); i++) begin
                        cnt_d[i] = '0;
                    end
                    err_d        = 1'b0;
                    slot_d       = 4'd0;
                    lbl_d        = '0;
                    best_label_d = '0;
                    best_cnt_d   = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (valid_c) begin
                    cnt_d[knn_info[LW-1:0]] = cnt_q[knn_info[LW-1:0]] + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
                if (slot_q == 4'(NBR_KNN - 1)) begin
                    slot_d  = 4'd0;
                    lbl_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            S_SCAN: begin
                if (take_c) begin
                    best_label_d = lbl_q;
                    best_cnt_d   = cnt_q[lbl_q];
                end
                // The last label's update is folded into the written result.
                if (lbl_q == LW'(NBR_LABELS - 1)) begin
                    label_out_d  = 8'(best_label_d);
                    vote_count_d = 8'(best_cnt_d);
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    lbl_d = lbl_q + LW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            slot_q       <= 4'd0;
            lbl_q        <= '0;
            for (int i = 0; i < int'(NBR_LABELS); i++) begin
                cnt_q[i] <= '0;
            end
            best_label_q <= '0;
            best_cnt_q   <= '0;
            label_out_q  <= 8'd0;
            vote_count_q <= 8'd0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            lbl_q        <= lbl_d;
            for (int i = 0; i < int'(NBR_LABELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            best_label_q <= best_label_d;
            best_cnt_q   <= best_cnt_d;
            label_out_q  <= label_out_d;
            vote_count_q <= vote_count_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign knn_id     = slot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign label_out  = label_out_q;
    assign vote_count = vote_count_q;
    assign err        = err_q;

endmodule

// File: doc/knn_label_vote.md
Name: knn_label_vote

Overview:
- Downstream consumer of the kNN core's sorted neighbour list.
- After the core has processed all data points for one test point, this block does three things:
  - walks the K list slots through the core's `knn_id` select;
  - collects the 8-bit `knn_info` label of each slot;
  - runs a majority vote and reports the winning class label.
- It works once per test point, under a start/done handshake from the controller.

Parameters:
- NBR_KNN, 4: number of neighbour slots to read (1..15; `knn_id` is 4 bits).
- NBR_LABELS, 4: number of valid class labels (labels 0..NBR_LABELS-1; 1..16).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a vote; sampled only in IDLE
- knn_id  output  4  slot select to the kNN core
- knn_info  input  8  label of the selected slot; combinational from knn_id, valid in the same cycle
- busy  output  1  high in every state other than IDLE
- done  output  1  one-cycle pulse when a result is written
- label_out  output  8  winning class label
- vote_count  output  8  number of votes for label_out
- err  output  1  sticky per vote: at least one slot held a label >= NBR_LABELS

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE;
  - knn_id, busy, done, label_out, vote_count, err all 0;
  - all per-label counters 0.
  - Reset has priority over every other event, including mid-vote; a partial vote is discarded with no done pulse.
- FSM states: IDLE, READ, SCAN, DONE.
- IDLE:
  - knn_id=0.
  - start=1 → clear all counters and err, slot index=0, go to READ.
  - start=0 → stay in IDLE.
- READ:
  - knn_id = slot index.
  - Each cycle, when knn_info < NBR_LABELS, increment counter[knn_info]; otherwise set err.
  - Slot index increments each cycle.
  - After slot NBR_KNN-1 is consumed, go to SCAN.
  - Takes exactly NBR_KNN cycles.
- SCAN:
  - Label index l runs 0..NBR_LABELS-1, one per cycle.
  - The running best is updated only when counter[l] > best_count (strict), so ties resolve to the lowest label.
  - best_label/best_count start at 0/0.
  - After l=NBR_LABELS-1, go to DONE.
  - Takes exactly NBR_LABELS cycles.
- DONE:
  - Register label_out=best_label and vote_count=best_count.
  - done=1 for this single cycle, then go to IDLE.
- Latency: start sampled at edge 0 → done high during cycle 1+NBR_KNN+NBR_LABELS; busy low again in the following cycle.
- start while busy: ignored and not queued. start held high across DONE: a new vote begins on the first IDLE cycle.
- label_out, vote_count and err hold their values until the next DONE, or until reset. err is cleared at the start of the next vote.
- All labels invalid: label_out=0, vote_count=0, err=1.
- Counter width is $clog2(NBR_KNN+1); vote_count is zero-extended to 8 bits. Counters never overflow, because at most NBR_KNN increments occur.
- Only knn_info bits below the label width are compared once the value is known to be < NBR_LABELS; the full 8-bit value is used for the validity check.

Test Plan:
- Basic majority: defaults; slot labels {2,1,2,3}; pulse start → knn_id sequence 0,1,2,3 over 4 cycles; done in cycle 9 after start; label_out=2, vote_count=2, err=0.
- Tie-break: labels {3,1,3,1} → label_out=1, vote_count=2. Labels {0,0,0,0} → label_out=0, vote_count=4.
- Invalid labels: labels {7,255,1,7} → label_out=1, vote_count=1, err=1. Labels {4,5,6,7} → label_out=0, vote_count=0, err=1. The next vote with {0,0,1,1} clears err to 0.
- Busy/handshake: assert start every cycle for 25 cycles → exactly two done pulses (cycles 9 and 19), busy=0 only in cycles 10 and 20, and no vote started mid-operation.
- Reset mid-operation: assert rst during cycle 3 of READ → next cycle all outputs 0, state IDLE, no done pulse. A following vote with {1,1,2,0} yields label_out=1, vote_count=2, proving counters were cleared.
- Parameter sweep: NBR_KNN=7, NBR_LABELS=3, labels {2,0,2,1,0,2,9} → knn_id runs 0..6, done 11 cycles after start, label_out=2, vote_count=3, err=1.
